// File: rtl/anchor_capture_ctrl.sv
// anchor_capture_ctrl: sequences one capture burst from the dual-AD9361 sample
// stream into samp_buff. The MCU arms the block and a sync_in edge starts the
// burst. After a programmable delay, cfg_len samples are gated into the buffer.
// The block then holds ready until the EBI reader has drained every 16-bit word.
//
// Handshake: there is no backpressure anywhere. s_valid marks a sample in the
// cycle it is presented. cap_valid is a one-cycle write strobe into samp_buff.
// rd_ena is one pulse per 16-bit word popped by the reader. Neither side can
// stall the other.
module anchor_capture_ctrl #(
  parameter int SAMP_WIDTH = 128,
  parameter int CNT_WIDTH  = 16,
  parameter int WPS_LOG2   = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  arm,
  input  logic                  abort,
  input  logic                  trig,
  input  logic [CNT_WIDTH-1:0]  cfg_delay,
  input  logic [CNT_WIDTH-1:0]  cfg_len,
  input  logic                  s_valid,
  input  logic [SAMP_WIDTH-1:0] s_data,
  input  logic                  rd_ena,
  output logic                  cap_valid,
  output logic [SAMP_WIDTH-1:0] cap_data,
  output logic                  cap_last,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            err,
  output logic [2:0]            dbg_state
);

  localparam int WCNT_WIDTH = CNT_WIDTH + WPS_LOG2;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ARMED   = 3'd1;
  localparam logic [2:0] ST_DELAY   = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_DRAIN   = 3'd4;

  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WCNT_WIDTH-1:0] WCNT_ONE = {{(WCNT_WIDTH-1){1'b0}}, 1'b1};

  logic [2:0]            state;
  logic [2:0]            state_nxt;
  logic                  trig_q;
  logic [CNT_WIDTH-1:0]  delay_q;
  logic [CNT_WIDTH-1:0]  len_q;
  logic [CNT_WIDTH-1:0]  dly_cnt;
  logic [CNT_WIDTH-1:0]  samp_cnt;
  logic [WCNT_WIDTH-1:0] word_cnt;
  logic [WCNT_WIDTH-1:0] len_words;

  logic trig_edge;
  logic arm_ok;
  logic arm_bad;
  logic dly_last;
  logic take_sample;
  logic last_sample;
  logic take_word;
  logic last_word;

  // Event decode; abort masks every event that would advance the burst.
  always_comb begin
    trig_edge   = trig & ~trig_q;
    arm_ok      = (state == ST_IDLE) & arm & ~abort & (cfg_len != '0);
    arm_bad     = (state == ST_IDLE) & arm & ~abort & (cfg_len == '0);
    dly_last    = (dly_cnt == (delay_q - CNT_ONE));
    take_sample = (state == ST_CAPTURE) & s_valid & ~abort;
    last_sample = take_sample & (samp_cnt == (len_q - CNT_ONE));
    len_words   = {len_q, {WPS_LOG2{1'b0}}};
    take_word   = (state == ST_DRAIN) & rd_ena & ~abort;
    last_word   = take_word & (word_cnt == (len_words - WCNT_ONE));
  end

  // Next-state logic; abort has priority over everything else.
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (arm_ok) state_nxt = ST_ARMED;
        ST_ARMED:   if (trig_edge) state_nxt = (delay_q != '0) ? ST_DELAY : ST_CAPTURE;
        ST_DELAY:   if (dly_last) state_nxt = ST_CAPTURE;
        ST_CAPTURE: if (last_sample) state_nxt = ST_DRAIN;
        ST_DRAIN:   if (last_word) state_nxt = ST_IDLE;
        default:    state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register and trigger edge history (tracked in every state).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      trig_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      trig_q <= trig;
    end
  end

  // Configuration is captured only on an accepted arm so it is stable for the burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      delay_q <= '0;
      len_q   <= '0;
    end else if (arm_ok) begin
      delay_q <= cfg_delay;
      len_q   <= cfg_len;
    end
  end

  // Delay, sample and word counters; each idles at zero outside its own state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_cnt  <= '0;
      samp_cnt <= '0;
      word_cnt <= '0;
    end else begin
      if ((state == ST_DELAY) && !abort && !dly_last) dly_cnt <= dly_cnt + CNT_ONE;
      else                                            dly_cnt <= '0;

      if (take_sample && !last_sample)                samp_cnt <= samp_cnt + CNT_ONE;
      else if ((state != ST_CAPTURE) || abort || last_sample) samp_cnt <= '0;

      if (take_word && !last_word)                    word_cnt <= word_cnt + WCNT_ONE;
      else if ((state != ST_DRAIN) || abort || last_word) word_cnt <= '0;
    end
  end

  // Registered write port into samp_buff plus the drain-complete pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_valid <= 1'b0;
      cap_last  <= 1'b0;
      cap_data  <= '0;
      done      <= 1'b0;
    end else begin
      cap_valid <= take_sample;
      cap_last  <= last_sample;
      if (take_sample) cap_data <= s_data;
      done      <= last_word;
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 3'b000;
    end else begin
      if (arm_bad) err[0] <= 1'b1;
      if (rd_ena && (state != ST_DRAIN)) err[1] <= 1'b1;
      if (trig_edge && ((state == ST_DELAY) || (state == ST_CAPTURE))) err[2] <= 1'b1;
    end
  end

  assign ready     = (state == ST_DRAIN);
  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_anchor_capture_ctrl.sv
// Bench for anchor_capture_ctrl. Random bursts are driven against a reference
// model that works from cycle numbers. A sample is expected when it is valid,
// at least delay+1 cycles after the trigger cycle, and among the first len such
// samples. Expected writes go into a queue. A monitor pops and compares them.
module tb_anchor_capture_ctrl;

  localparam int SW = 128;
  localparam int CW = 16;
  localparam int EW = 32 + 1 + SW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          arm, abort, trig, s_valid, rd_ena;
  logic [CW-1:0] cfg_delay, cfg_len;
  logic [SW-1:0] s_data;
  logic          cap_valid, cap_last, ready, busy, done;
  logic [SW-1:0] cap_data;
  logic [2:0]    err;
  logic [2:0]    dbg_state;

  logic [EW-1:0] exp_q[$];
  int            cyc = 0;
  int            checks = 0;
  int            failures = 0;
  int            done_seen = 0;
  int            done_exp = 0;
  logic [2:0]    err_exp = 3'b000;

  anchor_capture_ctrl #(.SAMP_WIDTH(SW), .CNT_WIDTH(CW), .WPS_LOG2(3)) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .trig(trig),
    .cfg_delay(cfg_delay), .cfg_len(cfg_len), .s_valid(s_valid), .s_data(s_data),
    .rd_ena(rd_ena), .cap_valid(cap_valid), .cap_data(cap_data), .cap_last(cap_last),
    .ready(ready), .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
  );

  // Clock and cycle index
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [SW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every write strobe must match the head of the expected queue
  always @(negedge clk) begin
    if (rst_n === 1'b1 && cap_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("cap_unexpected", 1, 0);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        chk("cap_cycle", SW'(cyc), SW'(e[EW-1 -: 32]));
        chk("cap_last",  SW'(cap_last), SW'(e[SW]));
        chk("cap_data",  cap_data, e[SW-1:0]);
      end
    end
    if (rst_n === 1'b1 && done === 1'b1) done_seen++;
  end

  // One burst: arm, trigger, capture (optionally abort / retrigger), drain (optionally reset)
  task automatic run_burst(input int dly, input int len, input int mode,
                           input int abort_at, input bit retrig, input bit rst_in_drain);
    int e_cyc, cnt, c, guard, words, phase;
    chk("pre_busy", SW'(busy), 0);
    cfg_delay = CW'(dly); cfg_len = CW'(len); arm = 1'b1;
    s_valid = 1'($urandom_range(0, 1)); s_data = rnd128();
    tick();
    arm = 1'b0; cfg_delay = CW'($urandom); cfg_len = CW'($urandom);
    chk("armed_busy", SW'(busy), 1);
    repeat ($urandom_range(0, 3)) begin
      s_valid = 1'($urandom_range(0, 1)); s_data = rnd128(); tick();
    end
    trig = 1'b1; e_cyc = cyc; s_valid = 1'($urandom_range(0, 1)); s_data = rnd128();
    tick();
    cnt = 0; guard = 0; phase = 0;
    while (cnt < len && !(abort_at >= 0 && cnt == abort_at) && guard < 2000) begin
      c = cyc;
      case (mode)
        0:       s_valid = 1'b1;
        1:       s_valid = 1'($urandom_range(0, 1));
        default: s_valid = ((c - e_cyc) % 4 == 0);
      endcase
      s_data = rnd128();
      if (retrig && phase == 0 && cnt >= 1) begin trig = 1'b0; phase = 1; end
      else if (phase == 1) begin trig = 1'b1; phase = 2; err_exp[2] = 1'b1; end
      if (s_valid && c >= e_cyc + dly + 1) begin
        exp_q.push_back({32'(c + 1), 1'(cnt == len - 1), s_data});
        cnt++;
      end
      tick();
      guard++;
    end
    if (guard >= 2000) chk("capture_timeout", 1, 0);
    s_valid = 1'($urandom_range(0, 1)); s_data = rnd128();
    if (abort_at >= 0) begin
      abort = 1'b1; tick(); abort = 1'b0; tick();
      chk("abort_busy", SW'(busy), 0);
      chk("abort_ready", SW'(ready), 0);
      chk("abort_capv", SW'(cap_valid), 0);
      trig = 1'b0; s_valid = 1'b0;
      chk("abort_err", SW'(err), SW'(err_exp));
      return;
    end
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin tick(); guard++; end
    if (exp_q.size() != 0) begin chk("queue_drain", exp_q.size(), 0); exp_q.delete(); end
    trig = 1'b0; s_valid = 1'b0;
    chk("drain_ready", SW'(ready), 1);
    chk("drain_busy", SW'(busy), 1);
    words = len * 8;
    for (int i = 0; i < words; i++) begin
      repeat ($urandom_range(0, 1)) tick();
      if (rst_in_drain && i == words / 2) begin
        #3 rst_n = 1'b0;
        #1;
        chk("rst_ready", SW'(ready), 0);
        chk("rst_busy", SW'(busy), 0);
        chk("rst_capv", SW'(cap_valid), 0);
        chk("rst_err", SW'(err), 0);
        err_exp = 3'b000;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_busy", SW'(busy), 0);
        chk("post_rst_ready", SW'(ready), 0);
        return;
      end
      chk("pre_word_ready", SW'(ready), 1);
      rd_ena = 1'b1; tick(); rd_ena = 1'b0;
      if (i == words - 1) begin
        done_exp++;
        chk("done_pulse", SW'(done), 1);
        chk("done_ready", SW'(ready), 0);
        chk("done_busy", SW'(busy), 0);
        tick();
        chk("done_clear", SW'(done), 0);
      end
    end
    chk("burst_err", SW'(err), SW'(err_exp));
  endtask

  // Stimulus sequence
  initial begin
    rst_n = 1'b0; arm = 1'b0; abort = 1'b0; trig = 1'b0; s_valid = 1'b0; rd_ena = 1'b0;
    cfg_delay = '0; cfg_len = '0; s_data = '0;
    repeat (3) tick();
    chk("rst_cap_valid", SW'(cap_valid), 0);
    chk("rst_cap_last", SW'(cap_last), 0);
    chk("rst_ready", SW'(ready), 0);
    chk("rst_busy", SW'(busy), 0);
    chk("rst_done", SW'(done), 0);
    chk("rst_err", SW'(err), 0);
    rst_n = 1'b1;
    tick();

    run_burst(0, 4, 0, -1, 1'b0, 1'b0);
    run_burst(10, 2, 0, -1, 1'b0, 1'b0);
    run_burst(2, 3, 2, -1, 1'b0, 1'b0);
    run_burst(1, 8, 0, 2, 1'b0, 1'b0);
    chk("abort_no_done", done_seen, done_exp);
    run_burst(0, 3, 1, -1, 1'b0, 1'b0);

    cfg_len = '0; cfg_delay = CW'(5); arm = 1'b1; tick(); arm = 1'b0;
    err_exp[0] = 1'b1;
    chk("err_len0", SW'(err), SW'(err_exp));
    chk("len0_busy", SW'(busy), 0);
    rd_ena = 1'b1; tick(); rd_ena = 1'b0;
    err_exp[1] = 1'b1;
    chk("err_rd_idle", SW'(err), SW'(err_exp));
    run_burst(0, 6, 0, -1, 1'b1, 1'b0);

    for (int n = 0; n < 6; n++)
      run_burst($urandom_range(0, 12), $urandom_range(1, 6), $urandom_range(0, 2), -1, 1'b0, 1'b0);

    run_burst($urandom_range(0, 4), 3, 0, -1, 1'b0, 1'b1);
    run_burst(0, 2, 0, -1, 1'b0, 1'b0);

    repeat (3) tick();
    chk("done_count", done_seen, done_exp);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound
  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
